// File: rtl/cordic_pkg.sv
// Shared defaults and helpers for the CORDIC job scheduler.
package cordic_pkg;

    localparam int CORDIC_DATA_WIDTH   = 16;
    localparam int CORDIC_NUM_REQ      = 4;
    localparam int CORDIC_PIPE_LATENCY = 16;
    localparam int CORDIC_ID_WIDTH     = $clog2(CORDIC_NUM_REQ);

    // Job tag that travels beside the core for the default configuration.
    typedef struct packed {
        logic                       valid;
        logic [CORDIC_ID_WIDTH-1:0] id;
    } cordic_tag_t;

    // Requester index reached by stepping 'offset' places past 'ptr', wrapping at n.
    function automatic int rr_next(input int ptr, input int offset, input int n);
        return (ptr + offset) % n;
    endfunction

endpackage

// File: rtl/cordic_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting index after the pointer, wrapping.
module cordic_rr_arbiter
    import cordic_pkg::*;
#(
    parameter  int NUM_REQ = CORDIC_NUM_REQ,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               enable_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               grant_valid_o
);

    logic [ID_W-1:0] cand;

    // Scan from the slot after the pointer; the first hit wins, no hit means no grant.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        cand          = '0;
        if (enable_i) begin
            for (int off = 1; off <= NUM_REQ; off++) begin
                cand = ID_W'(rr_next(int'(ptr_i), off, NUM_REQ));
                if (!grant_valid_o && req_i[cand]) begin
                    grant_valid_o = 1'b1;
                    grant_idx_o   = cand;
                end
            end
        end
        if (grant_valid_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/cordic_job_scheduler.sv
// Shares one pipelined CORDIC core among several requesters. A tag pipe running in
// lock-step with the core carries each job's requester id to the response port.
module cordic_job_scheduler
    import cordic_pkg::*;
#(
    parameter  int DATA_WIDTH   = CORDIC_DATA_WIDTH,
    parameter  int NUM_REQ      = CORDIC_NUM_REQ,
    parameter  int PIPE_LATENCY = CORDIC_PIPE_LATENCY,
    localparam int ID_W         = $clog2(NUM_REQ),
    localparam int CNT_W        = $clog2(PIPE_LATENCY + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_x,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_y,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_z,
    output logic                          core_enable,
    output logic [DATA_WIDTH-1:0]         core_xin,
    output logic [DATA_WIDTH-1:0]         core_yin,
    output logic [DATA_WIDTH-1:0]         core_zin,
    input  logic [DATA_WIDTH-1:0]         core_xout,
    input  logic [DATA_WIDTH-1:0]         core_yout,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_x,
    output logic [DATA_WIDTH-1:0]         rsp_y,
    output logic [CNT_W-1:0]              in_flight,
    output logic                          busy
);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    tag_t            tag_q [PIPE_LATENCY];
    tag_t            tag_in;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] in_flight_q, in_flight_d;
    logic [ID_W-1:0] grant_idx;
    logic            grant_valid;
    logic            stall;
    logic            rsp_fire;

    // The core only freezes when a finished result is waiting on the consumer.
    assign stall       = tag_q[PIPE_LATENCY-1].valid & ~rsp_ready;
    assign core_enable = ~stall;

    cordic_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i         (req_valid),
        .enable_i      (core_enable),
        .ptr_i         (rr_ptr_q),
        .grant_o       (req_ready),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    // Pointer moves to the winner so it becomes lowest priority next cycle.
    always_comb begin
        rr_ptr_d = grant_valid ? grant_idx : rr_ptr_q;
    end

    // Round-robin pointer; reset value makes requester 0 the first candidate.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            rr_ptr_q <= ID_W'(NUM_REQ - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Steer the granted requester's operands into the core; bubbles carry zeros.
    always_comb begin
        core_xin = '0;
        core_yin = '0;
        core_zin = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_valid && grant_idx == ID_W'(i)) begin
                core_xin = req_x[i*DATA_WIDTH +: DATA_WIDTH];
                core_yin = req_y[i*DATA_WIDTH +: DATA_WIDTH];
                core_zin = req_z[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign tag_in = '{valid: grant_valid, id: grant_idx};

    // Tag pipe: advances only with the core so tags stay aligned with core data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: ids are cleared with the valid bits; only valid matters, but rsp_id stays defined.
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else if (core_enable) begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign rsp_valid = tag_q[PIPE_LATENCY-1].valid;
    assign rsp_id    = tag_q[PIPE_LATENCY-1].id;
    assign rsp_x     = core_xout;
    assign rsp_y     = core_yout;
    assign rsp_fire  = rsp_valid & rsp_ready;

    // Occupancy: +1 per accept, -1 per delivered response, net zero when both happen.
    always_comb begin
        in_flight_d = in_flight_q;
        case ({grant_valid, rsp_fire})
            2'b10:   in_flight_d = in_flight_q + CNT_W'(1);
            2'b01:   in_flight_d = in_flight_q - CNT_W'(1);
            default: in_flight_d = in_flight_q;
        endcase
    end

    // Occupancy counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_flight_q <= '0;
        end else begin
            in_flight_q <= in_flight_d;
        end
    end

    assign in_flight = in_flight_q;
    assign busy      = (in_flight_q != '0);

endmodule

// File: tb/tb_cordic_job_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_cordic_job_scheduler;

    localparam int DW = 16;
    localparam int N  = 4;
    localparam int L  = 16;
    localparam int IW = 2;
    localparam int CW = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_x, req_y, req_z;
    logic              core_enable;
    logic [DW-1:0]     core_xin, core_yin, core_zin;
    logic [DW-1:0]     core_xout, core_yout;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [DW-1:0]     rsp_x, rsp_y;
    logic [CW-1:0]     in_flight;
    logic              busy;

    always #5 clk = ~clk;

    cordic_job_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_z       (req_z),
        .core_enable (core_enable),
        .core_xin    (core_xin),
        .core_yin    (core_yin),
        .core_zin    (core_zin),
        .core_xout   (core_xout),
        .core_yout   (core_yout),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_x       (rsp_x),
        .rsp_y       (rsp_y),
        .in_flight   (in_flight),
        .busy        (busy)
    );

    // Stand-in core: fixed latency, advances on core_enable, never cleared by reset.
    function automatic logic [DW-1:0] fx(input logic [DW-1:0] x, input logic [DW-1:0] z);
        return x ^ {z[7:0], z[15:8]};
    endfunction
    function automatic logic [DW-1:0] fy(input logic [DW-1:0] y, input logic [DW-1:0] z);
        return y + z;
    endfunction

    logic [DW-1:0] cpx [L];
    logic [DW-1:0] cpy [L];
    always @(posedge clk) begin
        if (core_enable) begin
            cpx[0] <= fx(core_xin, core_zin);
            cpy[0] <= fy(core_yin, core_zin);
            for (int i = 1; i < L; i++) begin
                cpx[i] <= cpx[i-1];
                cpy[i] <= cpy[i-1];
            end
        end
    end
    assign core_xout = cpx[L-1];
    assign core_yout = cpy[L-1];

    // Reference model: accepted jobs in order, stamped with the enabled-cycle count at accept.
    typedef struct {
        int            id;
        logic [DW-1:0] x, y, z;
        int            k;
    } job_t;

    job_t q[$];
    int   en_cnt;
    int   ptr;
    int   exp_g;
    bit   exp_rv;
    bit   exp_stall;
    logic [DW-1:0] cap_x, cap_y, cap_z;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle_begin(input logic [N-1:0] v, input logic rr);
        @(negedge clk);
        req_valid = v;
        rsp_ready = rr;
        for (int i = 0; i < N; i++) begin
            req_x[i*DW +: DW] = DW'($urandom);
            req_y[i*DW +: DW] = DW'($urandom);
            req_z[i*DW +: DW] = DW'($urandom);
        end
    endtask

    task automatic cycle_check();
        int exp_oh;
        #1;
        exp_rv    = (q.size() > 0) && (q[0].k + L == en_cnt);
        exp_stall = exp_rv && !rsp_ready;
        exp_g     = -1;
        if (!exp_stall) begin
            for (int o = 1; o <= N; o++) begin
                int c;
                c = (ptr + o) % N;
                if (exp_g < 0 && req_valid[c]) exp_g = c;
            end
        end
        exp_oh = (exp_g >= 0) ? (1 << exp_g) : 0;
        if (exp_g >= 0) begin
            cap_x = req_x[exp_g*DW +: DW];
            cap_y = req_y[exp_g*DW +: DW];
            cap_z = req_z[exp_g*DW +: DW];
        end else begin
            cap_x = '0;
            cap_y = '0;
            cap_z = '0;
        end
        check("core_enable", 32'(core_enable), 32'(!exp_stall));
        check("req_ready", 32'(req_ready), 32'(exp_oh));
        check("core_xin", 32'(core_xin), 32'(cap_x));
        check("core_yin", 32'(core_yin), 32'(cap_y));
        check("core_zin", 32'(core_zin), 32'(cap_z));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check("in_flight", 32'(in_flight), 32'(q.size()));
        check("busy", 32'(busy), 32'(q.size() != 0));
        if (exp_rv) begin
            check("rsp_id", 32'(rsp_id), 32'(q[0].id));
            check("rsp_x", 32'(rsp_x), 32'(fx(q[0].x, q[0].z)));
            check("rsp_y", 32'(rsp_y), 32'(fy(q[0].y, q[0].z)));
        end
    endtask

    task automatic cycle_end();
        int k_now;
        @(posedge clk);
        k_now = en_cnt;
        if (!exp_stall) en_cnt++;
        if (exp_rv && rsp_ready) void'(q.pop_front());
        if (exp_g >= 0) begin
            q.push_back('{id: exp_g, x: cap_x, y: cap_y, z: cap_z, k: k_now});
            ptr = exp_g;
        end
    endtask

    task automatic step(input logic [N-1:0] v, input logic rr);
        cycle_begin(v, rr);
        cycle_check();
        cycle_end();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        q.delete();
        ptr = N - 1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        int granted_at;
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        req_x     = '0;
        req_y     = '0;
        req_z     = '0;
        en_cnt    = 0;
        ptr       = N - 1;

        // Reset state.
        #3;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_flight", 32'(in_flight), 32'd0);
        check("rst_core_enable", 32'(core_enable), 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;

        // Single job from requester 1, latency of exactly L cycles.
        cycle_begin(4'b0010, 1'b1);
        req_x[1*DW +: DW] = 16'h26DD;
        req_y[1*DW +: DW] = 16'h0000;
        req_z[1*DW +: DW] = 16'h3244;
        cycle_check();
        check("d1_grant", 32'(req_ready), 32'h2);
        check("d1_xin", 32'(core_xin), 32'h26DD);
        check("d1_zin", 32'(core_zin), 32'h3244);
        cycle_end();
        repeat (L - 1) step(4'b0000, 1'b1);
        cycle_begin(4'b0000, 1'b1);
        cycle_check();
        check("d1_lat_valid", 32'(rsp_valid), 32'd1);
        check("d1_id", 32'(rsp_id), 32'd1);
        check("d1_rsp_x", 32'(rsp_x), 32'(fx(16'h26DD, 16'h3244)));
        check("d1_rsp_y", 32'(rsp_y), 32'(fy(16'h0000, 16'h3244)));
        cycle_end();
        repeat (3) step(4'b0000, 1'b1);

        // All requesters held valid: rotating grants, full pipe, accept+response in steady state.
        reset_dut();
        for (int c = 0; c < 20; c++) begin
            cycle_begin(4'b1111, 1'b1);
            cycle_check();
            check("d2_grant", 32'(req_ready), 32'(1 << (c % N)));
            if (c >= L) begin
                check("d2_rsp_id", 32'(rsp_id), 32'(c - L));
                check("d2_peak", 32'(in_flight), 32'd16);
            end
            cycle_end();
        end

        // Consumer backpressure for 5 cycles with requests still pending.
        for (int c = 0; c < 5; c++) begin
            cycle_begin(4'b1111, 1'b0);
            cycle_check();
            check("d3_enable", 32'(core_enable), 32'd0);
            check("d3_req_ready", 32'(req_ready), 32'd0);
            check("d3_in_flight", 32'(in_flight), 32'd16);
            cycle_end();
        end
        repeat (L + 4) step(4'b0000, 1'b1);
        check("d3_drained", 32'(q.size()), 32'(in_flight));

        // Reset while 8 jobs are in flight: all dropped, stale core data never reported.
        reset_dut();
        repeat (8) step(4'b0001, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("d4_rsp_valid", 32'(rsp_valid), 32'd0);
        check("d4_in_flight", 32'(in_flight), 32'd0);
        check("d4_busy", 32'(busy), 32'd0);
        q.delete();
        ptr = N - 1;
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (L + 8) step(4'b0000, 1'b1);

        // Requester 0 held, requester 2 raised at cycle 3: no starvation.
        reset_dut();
        granted_at = -1;
        for (int c = 0; c < 12; c++) begin
            cycle_begin((c >= 3) ? 4'b0101 : 4'b0001, 1'b1);
            cycle_check();
            if (c >= 3 && granted_at < 0 && req_ready[2]) granted_at = c;
            cycle_end();
        end
        check("d5_req2_granted", 32'(granted_at >= 3 && (granted_at - 3) < N), 32'd1);

        // Random traffic with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            step(N'($urandom), ($urandom_range(0, 3) != 0));
        end
        repeat (3 * L) step(4'b0000, 1'b1);
        check("final_empty", 32'(in_flight), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
